ccc_reconfig_ctrl: RTL and testbench
====================================

// Module: ccc_reconfig_ctrl
// PURPOSE
//  Sequencer for the fabric CCC/PLL: safely reprograms the CCC through its 8-bit APB config port.
//  Steps: move glitchless mux to alternate clock, hold PLL reset, burst-write config bytes, release,
//  qualify LOCK, switch back. Also supervises LOCK in run-time (sticky loss flag, loss counter).
//  Sits in PCLK domain between the system config master and the clk_div CCC instance.
// PARAMETERS
//  MUX_SETTLE   8      PCLK cycles held after each NGMUX_SEL change
//  LOCK_STABLE  64     consecutive synced-LOCK-high cycles required to declare lock
//  LOCK_TIMEOUT 65535  max cycles in WAIT_LOCK before error (16-bit counter)
// PORTS
//  PCLK            in   1  sole clock
//  PRESET_N        in   1  async active-low reset, synchronous deassert assumed upstream
//  start           in   1  1-cycle request to begin reconfiguration; ignored while busy=1
//  busy            out  1  high from accepted start until done/err
//  done            out  1  1-cycle pulse: reconfig complete, lock qualified
//  err             out  1  1-cycle pulse: lock timeout
//  wr_valid        in   1  config beat valid
//  wr_ready        out  1  beat accepted when wr_valid&wr_ready
//  wr_addr         in   6  CCC register address
//  wr_data         in   8  CCC register data
//  wr_last         in   1  final beat of burst
//  ccc_psel        out  1  APB select
//  ccc_penable     out  1  APB enable
//  ccc_pwrite      out  1  APB write (always 1 when psel=1)
//  ccc_paddr       out  6  APB address
//  ccc_pwdata      out  8  APB write data
//  ccc_lock        in   1  raw CCC LOCK, asynchronous, 2-FF synchronised internally
//  ccc_pll_arst_n  out  1  PLL async reset, active-low
//  ngmux_sel       out  1  0 = PLL output, 1 = alternate (safe) clock
//  lock_ok         out  1  PLL qualified-locked and monitor armed
//  lock_lost       out  1  sticky: qualified lock dropped
//  lock_lost_clr   in   1  clears lock_lost
//  lock_loss_cnt   out  8  saturating count of lock losses
// BEHAVIOUR
//  Reset: all APB outputs 0, ccc_pll_arst_n=1, ngmux_sel=0, busy/done/err/wr_ready/lock_ok/lock_lost=0,
//   lock_loss_cnt=0; FSM starts in INIT_LOCK (qualify power-up lock, busy=0, same timeout rule).
//  States: INIT_LOCK, IDLE, SW_OUT, PLL_RST, APB_SETUP, APB_ACCESS, RELEASE, WAIT_LOCK, SW_BACK.
//  IDLE --start--> SW_OUT: ngmux_sel=1, lock_ok=0, monitor disarmed, wait MUX_SETTLE cycles.
//  SW_OUT -> PLL_RST: ccc_pll_arst_n=0 for one cycle, then APB_SETUP.
//  APB_SETUP: wr_ready=1; waits indefinitely for wr_valid. On handshake: psel=1, penable=0, addr/data
//   registered -> APB_ACCESS next cycle (psel=1, penable=1, 1 cycle, no PREADY) -> psel/penable=0.
//   Beat with wr_last=1 -> RELEASE, else back to APB_SETUP. Min 3 cycles per beat; one beat per access.
//  RELEASE: ccc_pll_arst_n=1, clear counters -> WAIT_LOCK.
//  WAIT_LOCK: stable counter increments on synced LOCK=1, clears on any 0; reaching LOCK_STABLE ->
//   SW_BACK. Timeout counter reaching LOCK_TIMEOUT -> err pulse, ngmux_sel stays 1, lock_ok=0, IDLE.
//  SW_BACK: ngmux_sel=0, wait MUX_SETTLE, then done pulse, lock_ok=1, busy=0, IDLE.
//  INIT_LOCK uses WAIT_LOCK rules; success -> lock_ok=1, no done pulse; timeout -> err, IDLE.
//  Monitor: when lock_ok=1 and synced LOCK=0: lock_ok=0, lock_lost=1, cnt+=1 (holds at 255).
//   Set and lock_lost_clr in same cycle: set wins. Disarmed outside IDLE.
//  start during busy: dropped, no queueing. start and lock-loss same cycle: both take effect.
//  PRESET_N assertion mid-sequence: immediate return to reset values; APB transfer aborted.
// STRUCTURE
//  Package ccc_ctrl_pkg: state enum, CCC_ADDR_W=6, CCC_DATA_W=8, counter widths.
//  Sub-module ccc_lock_qual: 2-FF LOCK synchroniser + stable/timeout counters, outputs locked/timeout.
//  Top holds FSM, APB driver, monitor.
// TESTING
//  Power-up: LOCK high at cycle 10 -> lock_ok=1 at cycle ~10+2+64, no done, err=0.
//  Reconfig 3 beats (0x00=A5,0x01=3C,0x02=7F last) -> ngmux_sel=1, 3 APB setup/access pairs with
//   exact addr/data, pll_arst_n low 1 cycle, lock 200 cycles later -> done pulse, ngmux_sel=0.
//  LOCK never asserts after RELEASE -> err at LOCK_TIMEOUT, ngmux_sel=1, lock_ok=0.
//  LOCK glitches low at stable count 63 -> counter restarts, lock_ok delayed another 64 cycles.
//  Run-time loss x300 -> lock_lost=1, cnt=255 saturated; clr with simultaneous loss -> stays 1.
//  PRESET_N low during APB_ACCESS -> psel/penable=0 same cycle, pll_arst_n=1, ngmux_sel=0.

Source files
------------

// File: rtl/ccc_ctrl_pkg.sv
// rtl/ccc_ctrl_pkg.sv - shared types and widths for the CCC reconfiguration sequencer
package ccc_ctrl_pkg;

    localparam int CCC_ADDR_W = 6;
    localparam int CCC_DATA_W = 8;
    localparam int SETTLE_W   = 4;
    localparam int STABLE_W   = 7;
    localparam int TIMEOUT_W  = 16;
    localparam int LOSS_CNT_W = 8;

    typedef enum logic [3:0] {
        ST_INIT_LOCK,
        ST_IDLE,
        ST_SW_OUT,
        ST_PLL_RST,
        ST_APB_SETUP,
        ST_APB_ACCESS,
        ST_RELEASE,
        ST_WAIT_LOCK,
        ST_SW_BACK
    } state_t;

endpackage

// File: rtl/ccc_lock_qual.sv
// rtl/ccc_lock_qual.sv - LOCK synchroniser with stable-run and timeout qualification counters
module ccc_lock_qual
    import ccc_ctrl_pkg::*;
#(
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lock_raw,
    input  logic enable,
    output logic lock_sync,
    output logic locked,
    output logic timeout
);

    logic                 lock_meta;
    logic [STABLE_W-1:0]  stable_cnt;
    logic [TIMEOUT_W-1:0] timeout_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= lock_raw;
            lock_sync <= lock_meta;
        end
    end

    // Counters only run while qualifying, so each qualification starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt  <= '0;
            timeout_cnt <= '0;
        end else if (!enable) begin
            stable_cnt  <= '0;
            timeout_cnt <= '0;
        end else begin
            stable_cnt <= lock_sync ? stable_cnt + 1'b1 : '0;
            if (!timeout) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
        end
    end

    assign locked  = enable && lock_sync && (stable_cnt == STABLE_W'(LOCK_STABLE - 1));
    assign timeout = enable && (timeout_cnt == TIMEOUT_W'(LOCK_TIMEOUT));

endmodule

// File: rtl/ccc_reconfig_ctrl.sv
// rtl/ccc_reconfig_ctrl.sv - CCC/PLL reprogramming sequencer with APB driver and run-time LOCK monitor
module ccc_reconfig_ctrl
    import ccc_ctrl_pkg::*;
#(
    parameter int MUX_SETTLE   = 8,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                  PCLK,
    input  logic                  PRESET_N,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [CCC_ADDR_W-1:0] wr_addr,
    input  logic [CCC_DATA_W-1:0] wr_data,
    input  logic                  wr_last,
    output logic                  ccc_psel,
    output logic                  ccc_penable,
    output logic                  ccc_pwrite,
    output logic [CCC_ADDR_W-1:0] ccc_paddr,
    output logic [CCC_DATA_W-1:0] ccc_pwdata,
    input  logic                  ccc_lock,
    output logic                  ccc_pll_arst_n,
    output logic                  ngmux_sel,
    output logic                  lock_ok,
    output logic                  lock_lost,
    input  logic                  lock_lost_clr,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    state_t              state, next_state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                settle_done;
    logic                beat_last;
    logic                lock_sync, locked, timeout;
    logic                qual_en, wr_fire, lock_loss;

    assign settle_done = (settle_cnt == SETTLE_W'(MUX_SETTLE - 1));
    assign qual_en     = (state == ST_INIT_LOCK) || (state == ST_WAIT_LOCK);
    assign wr_fire     = wr_valid && wr_ready;
    assign lock_loss   = (state == ST_IDLE) && lock_ok && !lock_sync;
    assign ccc_pwrite  = ccc_psel;

    ccc_lock_qual #(
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_qual (
        .clk       (PCLK),
        .rst_n     (PRESET_N),
        .lock_raw  (ccc_lock),
        .enable    (qual_en),
        .lock_sync (lock_sync),
        .locked    (locked),
        .timeout   (timeout)
    );

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            state <= ST_INIT_LOCK;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        wr_ready   = 1'b0;
        case (state)
            ST_INIT_LOCK: begin
                busy = 1'b0;
                if (locked || timeout) next_state = ST_IDLE;
            end
            ST_IDLE: begin
                busy = 1'b0;
                if (start) next_state = ST_SW_OUT;
            end
            ST_SW_OUT:    if (settle_done) next_state = ST_PLL_RST;
            ST_PLL_RST:   next_state = ST_APB_SETUP;
            ST_APB_SETUP: begin
                wr_ready = 1'b1;
                if (wr_valid) next_state = ST_APB_ACCESS;
            end
            // Two cycles here: APB setup phase, then the enable phase.
            ST_APB_ACCESS: if (ccc_penable) next_state = beat_last ? ST_RELEASE : ST_APB_SETUP;
            ST_RELEASE:   next_state = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (locked)       next_state = ST_SW_BACK;
                else if (timeout) next_state = ST_IDLE;
            end
            ST_SW_BACK:   if (settle_done) next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            settle_cnt     <= '0;
            ccc_psel       <= 1'b0;
            ccc_penable    <= 1'b0;
            ccc_paddr      <= '0;
            ccc_pwdata     <= '0;
            beat_last      <= 1'b0;
            ccc_pll_arst_n <= 1'b1;
            ngmux_sel      <= 1'b0;
            lock_ok        <= 1'b0;
            lock_lost      <= 1'b0;
            lock_loss_cnt  <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            if ((state == ST_SW_OUT || state == ST_SW_BACK) && !settle_done) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else begin
                settle_cnt <= '0;
            end

            // Registered so the PLL reset never sees decode glitches.
            ccc_pll_arst_n <= (next_state != ST_PLL_RST);
            done           <= (state == ST_SW_BACK) && settle_done;
            err            <= qual_en && timeout && !locked;

            if (wr_fire) begin
                ccc_psel    <= 1'b1;
                ccc_penable <= 1'b0;
                ccc_paddr   <= wr_addr;
                ccc_pwdata  <= wr_data;
                beat_last   <= wr_last;
            end else if (state == ST_APB_ACCESS) begin
                if (!ccc_penable) begin
                    ccc_penable <= 1'b1;
                end else begin
                    ccc_psel    <= 1'b0;
                    ccc_penable <= 1'b0;
                end
            end

            if (state == ST_IDLE && start) begin
                ngmux_sel <= 1'b1;
            end else if (state == ST_WAIT_LOCK && locked) begin
                ngmux_sel <= 1'b0;
            end

            if ((state == ST_INIT_LOCK && locked) || (state == ST_SW_BACK && settle_done)) begin
                lock_ok <= 1'b1;
            end else if (lock_loss || (state == ST_IDLE && start)) begin
                lock_ok <= 1'b0;
            end

            // A new loss outranks a clear in the same cycle.
            if (lock_loss) begin
                lock_lost <= 1'b1;
            end else if (lock_lost_clr) begin
                lock_lost <= 1'b0;
            end

            if (lock_loss && lock_loss_cnt != '1) begin
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ccc_reconfig_ctrl.sv
// tb/tb_ccc_reconfig_ctrl.sv - directed vector bench for ccc_reconfig_ctrl
module tb_ccc_reconfig_ctrl;

    localparam int TB_TIMEOUT = 3000;

    logic       pclk = 1'b0;
    logic       preset_n = 1'b0;
    logic       start = 1'b0;
    logic       wr_valid = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_last = 1'b0;
    logic       ccc_lock = 1'b0;
    logic       lock_lost_clr = 1'b0;

    logic       busy, done, err, wr_ready;
    logic       ccc_psel, ccc_penable, ccc_pwrite;
    logic [5:0] ccc_paddr;
    logic [7:0] ccc_pwdata;
    logic       ccc_pll_arst_n, ngmux_sel, lock_ok, lock_lost;
    logic [7:0] lock_loss_cnt;

    int total = 0;
    int bad = 0;
    int done_at, ngmux_at, done_cnt, err_cnt, cyc, lock_at;
    logic seen, arst_low_seen;

    typedef struct {
        logic       v;
        logic [5:0] a;
        logic [7:0] d;
        logic       l;
        logic       rdy;
        logic       psel;
        logic       pen;
        logic [5:0] pa;
        logic [7:0] pd;
    } vec_t;

    vec_t vecs [11];

    always #5 pclk = ~pclk;

    ccc_reconfig_ctrl #(
        .MUX_SETTLE   (8),
        .LOCK_STABLE  (64),
        .LOCK_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .PCLK           (pclk),
        .PRESET_N       (preset_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_last        (wr_last),
        .ccc_psel       (ccc_psel),
        .ccc_penable    (ccc_penable),
        .ccc_pwrite     (ccc_pwrite),
        .ccc_paddr      (ccc_paddr),
        .ccc_pwdata     (ccc_pwdata),
        .ccc_lock       (ccc_lock),
        .ccc_pll_arst_n (ccc_pll_arst_n),
        .ngmux_sel      (ngmux_sel),
        .lock_ok        (lock_ok),
        .lock_lost      (lock_lost),
        .lock_lost_clr  (lock_lost_clr),
        .lock_loss_cnt  (lock_loss_cnt)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic write_beat(input logic [5:0] a, input logic [7:0] d, input logic l);
        int n = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_last  = l;
        while (!wr_ready && n < 50) begin
            tick();
            n++;
        end
        if (!wr_ready) check("write_beat_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic wait_for_done(input int limit, output int cycles, output logic got);
        got = 1'b0;
        cycles = 0;
        while (!got && cycles < limit) begin
            tick();
            cycles++;
            if (done) got = 1'b1;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 6'h00, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 8'h00};
        vecs[1]  = '{1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 8'hA5};
        vecs[2]  = '{1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 8'hA5};
        vecs[3]  = '{1'b0, 6'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 8'h00};
        vecs[4]  = '{1'b1, 6'h01, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 8'h00};
        vecs[5]  = '{1'b1, 6'h02, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 6'h01, 8'h3C};
        vecs[6]  = '{1'b1, 6'h02, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b1, 6'h01, 8'h3C};
        vecs[7]  = '{1'b1, 6'h02, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 8'h00};
        vecs[8]  = '{1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 6'h02, 8'h7F};
        vecs[9]  = '{1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 6'h02, 8'h7F};
        vecs[10] = '{1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00};

        // Reset values
        repeat (3) tick();
        check("rst_psel", ccc_psel, 0);
        check("rst_penable", ccc_penable, 0);
        check("rst_pwrite", ccc_pwrite, 0);
        check("rst_paddr", ccc_paddr, 0);
        check("rst_pwdata", ccc_pwdata, 0);
        check("rst_arst_n", ccc_pll_arst_n, 1);
        check("rst_ngmux", ngmux_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_lock_flags", {lock_ok, lock_lost}, 0);
        check("rst_loss_cnt", lock_loss_cnt, 0);

        // Power-up qualification: LOCK rises 10 cycles after reset release
        preset_n = 1'b1;
        repeat (10) tick();
        ccc_lock = 1'b1;
        done_cnt = 0;
        err_cnt = 0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (k == 65) check("pwrup_lock_ok_early", lock_ok, 0);
            if (k == 66) check("pwrup_lock_ok", lock_ok, 1);
        end
        check("pwrup_no_done", done_cnt, 0);
        check("pwrup_no_err", err_cnt, 0);
        check("pwrup_busy", busy, 0);

        // Reconfiguration with a 3-beat burst; a second start mid-sequence is dropped
        pulse_start();
        ccc_lock = 1'b0;
        check("sw_out_busy", busy, 1);
        check("sw_out_ngmux", ngmux_sel, 1);
        check("sw_out_lock_ok", lock_ok, 0);
        arst_low_seen = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            if (i == 3) start = 1'b1;
            tick();
            start = 1'b0;
            if (!ccc_pll_arst_n) arst_low_seen = 1'b1;
        end
        check("settle_arst_high", arst_low_seen, 0);
        tick();
        check("pll_rst_low", ccc_pll_arst_n, 0);
        check("pll_rst_wr_ready", wr_ready, 0);
        tick();
        check("pll_rst_released", ccc_pll_arst_n, 1);

        for (int r = 0; r < 11; r++) begin
            wr_valid = vecs[r].v;
            wr_addr  = vecs[r].a;
            wr_data  = vecs[r].d;
            wr_last  = vecs[r].l;
            check($sformatf("vec%0d_wr_ready", r), wr_ready, vecs[r].rdy);
            check($sformatf("vec%0d_psel", r), ccc_psel, vecs[r].psel);
            check($sformatf("vec%0d_penable", r), ccc_penable, vecs[r].pen);
            check($sformatf("vec%0d_pwrite", r), ccc_pwrite, vecs[r].psel);
            if (vecs[r].psel) begin
                check($sformatf("vec%0d_paddr", r), ccc_paddr, vecs[r].pa);
                check($sformatf("vec%0d_pwdata", r), ccc_pwdata, vecs[r].pd);
            end
            check($sformatf("vec%0d_mux_arst", r), {ngmux_sel, ccc_pll_arst_n}, 2'b11);
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;

        repeat (200) tick();
        check("wait_lock_busy", busy, 1);
        ccc_lock = 1'b1;
        done_at = 0;
        ngmux_at = 0;
        done_cnt = 0;
        err_cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (!ngmux_sel && ngmux_at == 0) ngmux_at = k;
            if (err) err_cnt++;
        end
        check("reconf_ngmux_back_at", ngmux_at, 66);
        check("reconf_done_at", done_at, 74);
        check("reconf_done_once", done_cnt, 1);
        check("reconf_no_err", err_cnt, 0);
        check("reconf_lock_ok", lock_ok, 1);
        check("reconf_no_requeue", busy, 0);

        // LOCK never returns: timeout
        pulse_start();
        ccc_lock = 1'b0;
        write_beat(6'h10, 8'h55, 1'b1);
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < TB_TIMEOUT + 200) begin
            tick();
            cyc++;
            if (err) seen = 1'b1;
        end
        check("timeout_err_seen", seen, 1);
        check("timeout_latency", (cyc >= TB_TIMEOUT + 3) && (cyc <= TB_TIMEOUT + 5), 1);
        check("timeout_ngmux", ngmux_sel, 1);
        check("timeout_lock_ok", lock_ok, 0);
        check("timeout_busy", busy, 0);
        tick();
        check("timeout_err_pulse", err, 0);

        // Glitch on LOCK when the stable count is at 63 restarts qualification
        pulse_start();
        write_beat(6'h20, 8'h01, 1'b1);
        repeat (3) tick();
        ccc_lock = 1'b1;
        done_at = 0;
        ngmux_at = 0;
        for (int k = 1; k <= 160; k++) begin
            tick();
            if (k == 63) ccc_lock = 1'b0;
            if (k == 64) ccc_lock = 1'b1;
            if (done && done_at == 0) done_at = k;
            if (!ngmux_sel && ngmux_at == 0) ngmux_at = k;
        end
        check("glitch_ngmux_back_at", ngmux_at, 130);
        check("glitch_done_at", done_at, 138);
        check("glitch_lock_ok", lock_ok, 1);
        check("pre_loss_flags", {lock_lost, lock_loss_cnt}, 9'h000);

        // 300 run-time losses saturate the counter
        for (int n = 0; n < 300; n++) begin
            ccc_lock = 1'b0;
            repeat (3) tick();
            if (n == 0) begin
                check("loss1_lost", lock_lost, 1);
                check("loss1_cnt", lock_loss_cnt, 1);
                check("loss1_lock_ok", lock_ok, 0);
            end
            ccc_lock = 1'b1;
            repeat (2) tick();
            pulse_start();
            write_beat(6'h00, 8'h00, 1'b1);
            wait_for_done(200, cyc, seen);
            if (!seen) begin
                check("loss_loop_done", seen, 1);
                break;
            end
        end
        check("loss_sat_cnt", lock_loss_cnt, 255);
        check("loss_sat_lost", lock_lost, 1);

        lock_lost_clr = 1'b1;
        tick();
        lock_lost_clr = 1'b0;
        check("lost_clr", lock_lost, 0);
        ccc_lock = 1'b0;
        repeat (2) tick();
        lock_lost_clr = 1'b1;
        tick();
        lock_lost_clr = 1'b0;
        check("set_beats_clr", lock_lost, 1);
        check("sat_hold_cnt", lock_loss_cnt, 255);
        check("set_beats_clr_lock_ok", lock_ok, 0);
        lock_lost_clr = 1'b1;
        tick();
        lock_lost_clr = 1'b0;
        check("lost_clr_again", lock_lost, 0);
        ccc_lock = 1'b1;
        repeat (2) tick();

        // Reset asserted during an APB access phase
        pulse_start();
        wr_valid = 1'b1;
        wr_addr  = 6'h3F;
        wr_data  = 8'hEE;
        wr_last  = 1'b1;
        cyc = 0;
        while (!wr_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        wr_valid = 1'b0;
        tick();
        check("pre_rst_access", {ccc_psel, ccc_penable, ccc_paddr, ccc_pwdata}, {2'b11, 6'h3F, 8'hEE});
        #2;
        preset_n = 1'b0;
        #1;
        check("mid_rst_apb", {ccc_psel, ccc_penable}, 0);
        check("mid_rst_arst_n", ccc_pll_arst_n, 1);
        check("mid_rst_ngmux", ngmux_sel, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cnt", lock_loss_cnt, 0);
        tick();
        preset_n = 1'b1;
        lock_at = 0;
        done_cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (lock_ok && lock_at == 0) lock_at = k;
            if (done) done_cnt++;
        end
        check("post_rst_lock_at", lock_at, 66);
        check("post_rst_no_done", done_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
